// File: rtl/truth_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker: state encoding,
// settle-timer width and the vector-count helper used by RTL and benches.
package truth_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W     = 4;
  localparam int N_IN_DEFAULT = 2;
  localparam int V_DEFAULT    = 1 << N_IN_DEFAULT;

  // Number of input combinations for an expression with n_in inputs.
  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_sweep_checker_settle_timer.sv
// Loadable down-counter with a zero flag; paces the hold interval between
// driving a vector and sampling the expression's outputs.
module truth_sweep_checker_settle_timer
  import truth_sweep_checker_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/truth_sweep_checker.sv
// Truth-table sweep checker: walks every input vector of a small expression,
// samples its SoP/PoS outputs after a settle interval and scores them against EXPECT.
module truth_sweep_checker
  import truth_sweep_checker_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b0110
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_sop_in,
  input  logic                    i_pos_in,
  output logic [N_IN-1:0]         o_vec_out,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [N_IN:0]           o_err_count,
  output logic [N_IN-1:0]         o_first_err_idx,
  output logic                    o_first_err_valid,
  output logic [(1<<N_IN)-1:0]    o_sop_table,
  output logic [(1<<N_IN)-1:0]    o_pos_table
);

  // state  | meaning
  // IDLE   | waiting for start, outputs at reset values
  // HOLD   | vector driven, settle timer running
  // SAMPLE | one cycle; outputs captured and scored on the exiting edge
  // DONE   | results frozen until the next start

  localparam int V = vec_count(N_IN);

  localparam logic [N_IN-1:0]     VEC_LAST    = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);
  // With no settle interval the sweep skips HOLD and samples every cycle.
  localparam state_t              WAIT_STATE  = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

  state_t r_state;
  state_t w_state_nxt;

  logic w_clear;
  logic w_sample;
  logic w_advance;
  logic w_finish;
  logic w_timer_load;
  logic w_timer_en;
  logic w_timer_zero;
  logic w_exp_bit;
  logic w_mismatch;

  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic [N_IN:0]   r_err_count;
  logic [N_IN-1:0] r_first_err_idx;
  logic            r_first_err_valid;
  logic [V-1:0]    r_sop_table;
  logic [V-1:0]    r_pos_table;

  truth_sweep_checker_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_timer_load),
    .i_en       (w_timer_en),
    .i_load_val (SETTLE_LOAD),
    .o_zero     (w_timer_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_sample     = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    w_timer_load = 1'b0;
    w_timer_en   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_clear      = 1'b1;
          w_timer_load = 1'b1;
          w_state_nxt  = WAIT_STATE;
        end
      end
      ST_HOLD: begin
        w_timer_en = 1'b1;
        if (w_timer_zero) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_sample = 1'b1;
        if (r_vec == VEC_LAST) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_advance    = 1'b1;
          w_timer_load = 1'b1;
          w_state_nxt  = WAIT_STATE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One error per vector, however many of the two outputs disagree.
  assign w_exp_bit  = EXPECT[r_vec];
  assign w_mismatch = (i_sop_in != w_exp_bit) || (i_pos_in != w_exp_bit);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vec             <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
      r_sop_table       <= '0;
      r_pos_table       <= '0;
    end else if (w_clear) begin
      r_vec             <= '0;
      r_busy            <= 1'b1;
      r_done            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_idx   <= '0;
      r_first_err_valid <= 1'b0;
      r_sop_table       <= '0;
      r_pos_table       <= '0;
    end else if (w_sample) begin
      r_sop_table[r_vec] <= i_sop_in;
      r_pos_table[r_vec] <= i_pos_in;
      if (w_mismatch) begin
        r_err_count <= r_err_count + (N_IN+1)'(1);
        if (!r_first_err_valid) begin
          r_first_err_idx   <= r_vec;
          r_first_err_valid <= 1'b1;
        end
      end
      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_advance) begin
        r_vec <= r_vec + N_IN'(1);
      end
    end
  end

  assign o_vec_out         = r_vec;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_pass            = r_done && (r_err_count == '0);
  assign o_err_count       = r_err_count;
  assign o_first_err_idx   = r_first_err_idx;
  assign o_first_err_valid = r_first_err_valid;
  assign o_sop_table       = r_sop_table;
  assign o_pos_table       = r_pos_table;

endmodule

// File: tb/tb_truth_sweep_checker.sv
// Scoreboard bench for truth_sweep_checker: two configurations, expected sweep
// results computed from truth tables and queued; monitors score them on done.
module tb_truth_sweep_checker;
  import truth_sweep_checker_pkg::*;

  localparam int          NA = 2;
  localparam int          SA = 1;
  localparam int          VA = 4;
  localparam logic [3:0]  EA = 4'b0110;
  localparam int          NB = 3;
  localparam int          SB = 0;
  localparam int          VB = 8;
  localparam logic [7:0]  EB = 8'h96;

  typedef struct {
    int          k;
    int          done_cyc;
    logic [4:0]  err;
    logic [3:0]  fidx;
    logic        fval;
    logic [15:0] sop_t;
    logic [15:0] pos_t;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic rst, start_a, start_b;
  logic [3:0] eut_sop_a, eut_pos_a;
  logic [7:0] eut_sop_b, eut_pos_b;

  logic        sop_a, pos_a, busy_a, done_a, pass_a, fval_a;
  logic [1:0]  vec_a, fidx_a;
  logic [2:0]  err_a;
  logic [3:0]  sop_t_a, pos_t_a;
  logic        sop_b, pos_b, busy_b, done_b, pass_b, fval_b;
  logic [2:0]  vec_b, fidx_b;
  logic [3:0]  err_b;
  logic [7:0]  sop_t_b, pos_t_b;

  // Expression under test: a lookup table indexed by the driven vector.
  assign sop_a = eut_sop_a[vec_a];
  assign pos_a = eut_pos_a[vec_a];
  assign sop_b = eut_sop_b[vec_b];
  assign pos_b = eut_pos_b[vec_b];

  truth_sweep_checker #(.N_IN(NA), .SETTLE(SA), .EXPECT(EA)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_sop_in(sop_a), .i_pos_in(pos_a),
    .o_vec_out(vec_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_err_count(err_a), .o_first_err_idx(fidx_a), .o_first_err_valid(fval_a),
    .o_sop_table(sop_t_a), .o_pos_table(pos_t_a)
  );

  truth_sweep_checker #(.N_IN(NB), .SETTLE(SB), .EXPECT(EB)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_sop_in(sop_b), .i_pos_in(pos_b),
    .o_vec_out(vec_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_err_count(err_b), .o_first_err_idx(fidx_b), .o_first_err_valid(fval_b),
    .o_sop_table(sop_t_b), .o_pos_table(pos_t_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: score a whole sweep from the truth tables alone.
  function automatic exp_t model(input int nv, input logic [15:0] expt,
                                 input logic [15:0] st, input logic [15:0] pt,
                                 input int k, input int settle);
    exp_t e;
    e.k = k;
    e.done_cyc = k + nv * (settle + 1);
    e.err = '0; e.fidx = '0; e.fval = 1'b0; e.sop_t = '0; e.pos_t = '0;
    for (int i = 0; i < nv; i++) begin
      e.sop_t[i] = st[i];
      e.pos_t[i] = pt[i];
      if (st[i] !== expt[i] || pt[i] !== expt[i]) begin
        e.err = e.err + 5'd1;
        if (!e.fval) begin
          e.fidx = i[3:0];
          e.fval = 1'b1;
        end
      end
    end
    return e;
  endfunction

  function automatic int vec_at(input int k, input int s, input int nv);
    int idx;
    idx = (cyc - k) / (s + 1);
    if (idx > nv - 1) idx = nv - 1;
    return idx;
  endfunction

  task automatic check_done(input string tag, input exp_t e, input int nv,
                            input logic [15:0] vec, input logic busy, input logic pass,
                            input logic [4:0] err, input logic [3:0] fidx, input logic fval,
                            input logic [15:0] st, input logic [15:0] pt);
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_vec_final"}, 32'(vec), nv - 1);
    chk({tag, "_busy_low"}, 32'(busy), 0);
    chk({tag, "_err_count"}, 32'(err), 32'(e.err));
    chk({tag, "_first_err_idx"}, 32'(fidx), 32'(e.fidx));
    chk({tag, "_first_err_valid"}, 32'(fval), 32'(e.fval));
    chk({tag, "_sop_table"}, 32'(st), 32'(e.sop_t));
    chk({tag, "_pos_table"}, 32'(pt), 32'(e.pos_t));
    chk({tag, "_pass"}, 32'(pass), (e.err == 0) ? 1 : 0);
  endtask

  task automatic unexpected_done(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s_unexpected_done: done rose with no sweep pending (cycle %0d)", tag, cyc);
  endtask

  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  always @(negedge clk) begin
    if (busy_a && q_a.size() > 0) chk("a_vec_timing", 32'(vec_a), vec_at(q_a[0].k, SA, VA));
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) unexpected_done("a");
      else begin
        ea = q_a.pop_front();
        check_done("a", ea, VA, 16'(vec_a), busy_a, pass_a, 5'(err_a), 4'(fidx_a), fval_a,
                   16'(sop_t_a), 16'(pos_t_a));
      end
    end
    done_a_q = done_a;
  end

  always @(negedge clk) begin
    if (busy_b && q_b.size() > 0) chk("b_vec_timing", 32'(vec_b), vec_at(q_b[0].k, SB, VB));
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) unexpected_done("b");
      else begin
        eb = q_b.pop_front();
        check_done("b", eb, VB, 16'(vec_b), busy_b, pass_b, 5'(err_b), 4'(fidx_b), fval_b,
                   16'(sop_t_b), 16'(pos_t_b));
      end
    end
    done_b_q = done_b;
  end

  task automatic set_start(input bit use_b, input logic v);
    if (use_b) start_b = v;
    else start_a = v;
  endtask

  task automatic sweep(input bit use_b, input logic [7:0] st, input logic [7:0] pt, input bit jitter);
    int k, dcyc, nv, s, budget;
    exp_t e;
    nv = use_b ? VB : VA;
    s  = use_b ? SB : SA;
    if (use_b) begin eut_sop_b = st; eut_pos_b = pt; end
    else begin eut_sop_a = st[3:0]; eut_pos_a = pt[3:0]; end
    @(negedge clk);
    k = cyc + 1;
    dcyc = k + nv * (s + 1);
    e = model(nv, use_b ? 16'(EB) : 16'(EA), 16'(st), 16'(pt), k, s);
    if (use_b) q_b.push_back(e);
    else q_a.push_back(e);
    set_start(use_b, 1'b1);
    @(negedge clk);
    set_start(use_b, 1'b0);
    budget = 0;
    while (!(use_b ? done_b : done_a) && budget < 200) begin
      // Stray start pulses mid-sweep must be ignored; stop before the DONE cycle.
      if (jitter && (cyc + 1 <= dcyc)) set_start(use_b, 1'($urandom_range(0, 1)));
      @(negedge clk);
      budget++;
    end
    set_start(use_b, 1'b0);
    if (!(use_b ? done_b : done_a)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sweep_timeout: done still low after %0d cycles", use_b ? "b" : "a", budget);
      if (use_b) q_b.delete();
      else q_a.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_a_vec"}, 32'(vec_a), 0);
    chk({tag, "_a_busy"}, 32'(busy_a), 0);
    chk({tag, "_a_done"}, 32'(done_a), 0);
    chk({tag, "_a_pass"}, 32'(pass_a), 0);
    chk({tag, "_a_err"}, 32'(err_a), 0);
    chk({tag, "_a_fidx"}, 32'(fidx_a), 0);
    chk({tag, "_a_fval"}, 32'(fval_a), 0);
    chk({tag, "_a_sop_t"}, 32'(sop_t_a), 0);
    chk({tag, "_a_pos_t"}, 32'(pos_t_a), 0);
    chk({tag, "_a_state"}, 32'(dut_a.r_state), 32'(ST_IDLE));
  endtask

  task automatic reset_mid_a();
    int k;
    eut_sop_a = 4'b0110;
    eut_pos_a = 4'b0110;
    @(negedge clk);
    k = cyc + 1;
    q_a.push_back(model(VA, 16'(EA), 16'h0006, 16'h0006, k, SA));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc < k + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q_a.delete();
    check_reset_a("midreset");
    rst = 1'b0;
  endtask

  task automatic held_start_a(input logic [3:0] st, input logic [3:0] pt);
    int k1, d1, k2, d2;
    eut_sop_a = st;
    eut_pos_a = pt;
    @(negedge clk);
    k1 = cyc + 1;
    d1 = k1 + VA * (SA + 1);
    k2 = d1 + 1;
    d2 = k2 + VA * (SA + 1);
    q_a.push_back(model(VA, 16'(EA), 16'(st), 16'(pt), k1, SA));
    q_a.push_back(model(VA, 16'(EA), 16'(st), 16'(pt), k2, SA));
    start_a = 1'b1;
    for (int t = 0; t < 4 * (d2 - k1); t++) begin
      @(negedge clk);
      if (cyc == d1) chk("held_done_high", 32'(done_a), 1);
      if (cyc == d1 + 1) begin
        chk("held_done_one_cycle", 32'(done_a), 0);
        chk("held_restart_busy", 32'(busy_a), 1);
      end
      if (cyc >= d2) break;
    end
    start_a = 1'b0;
    chk("held_second_done", 32'(done_a), 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    eut_sop_a = '0; eut_pos_a = '0;
    eut_sop_b = '0; eut_pos_b = '0;
    repeat (3) @(negedge clk);
    check_reset_a("por");
    chk("por_b_done", 32'(done_b), 0);
    chk("por_b_busy", 32'(busy_b), 0);
    chk("por_b_err", 32'(err_b), 0);
    chk("por_b_tables", {16'(sop_t_b), 16'(pos_t_b)}, 0);
    rst = 1'b0;

    sweep(1'b0, 8'h06, 8'h06, 1'b0);
    sweep(1'b0, 8'h06, 8'h00, 1'b0);
    sweep(1'b0, 8'h0E, 8'h0E, 1'b0);
    for (int i = 0; i < 6; i++) sweep(1'b0, 8'($urandom), 8'($urandom), 1'b1);
    reset_mid_a();
    sweep(1'b0, 8'h06, 8'h06, 1'b0);
    held_start_a(4'b0110, 4'($urandom));

    sweep(1'b1, 8'h96, 8'h96, 1'b0);
    sweep(1'b1, 8'h96, 8'h96 ^ 8'h10, 1'b0);
    for (int i = 0; i < 4; i++) sweep(1'b1, 8'($urandom), 8'($urandom), 1'b1);

    repeat (3) @(negedge clk);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
